// File: rtl/uart_rx_pkg.sv
// Shared types and timing offsets for the UART receiver control path.
package uart_rx_pkg;

  localparam int DATA_W_DEF     = 8;
  localparam int PRESCALE_W_DEF = 6;

  // Offsets from the mid-bit edge H = P/2.
  // EN_OFS: the sampler's majority vote is registered and ready here.
  // STOP_OFS: the stop checker flag is valid here, and the frame is decided.
  localparam int EN_OFS   = 2;
  localparam int STOP_OFS = 3;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

endpackage

// File: rtl/uart_rx_fsm_if.sv
// Line, checker and enable signals between the RX control FSM and its datapath.
interface uart_rx_fsm_if #(
  parameter int PRESCALE_W = 6
);
  logic                  RX_IN;
  logic [PRESCALE_W-1:0] Prescale;
  logic                  PAR_EN;
  logic                  strt_glitch;
  logic                  par_err;
  logic                  stp_err;
  logic [PRESCALE_W-1:0] edge_cnt;
  logic [3:0]            bit_cnt;
  logic                  dat_samp_en;
  logic                  strt_chk_en;
  logic                  deser_en;
  logic                  par_chk_en;
  logic                  stp_chk_en;
  logic                  data_valid;
  logic                  frame_err;

  // FSM side
  modport master (
    input  RX_IN, Prescale, PAR_EN, strt_glitch, par_err, stp_err,
    output edge_cnt, bit_cnt, dat_samp_en, strt_chk_en, deser_en,
           par_chk_en, stp_chk_en, data_valid, frame_err
  );

  // Datapath / environment side
  modport slave (
    output RX_IN, Prescale, PAR_EN, strt_glitch, par_err, stp_err,
    input  edge_cnt, bit_cnt, dat_samp_en, strt_chk_en, deser_en,
           par_chk_en, stp_chk_en, data_valid, frame_err
  );
endinterface

// File: rtl/uart_rx_edge_bit_counter.sv
// Oversampling edge counter and bit counter with a prescale latched while idle.
module uart_rx_edge_bit_counter #(
  parameter int PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  RST_n,
  input  logic                  clr,       // force both counters to 0
  input  logic                  load,      // track prescale (held while idle)
  input  logic [PRESCALE_W-1:0] prescale,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic [3:0]            bit_cnt,
  output logic [PRESCALE_W-1:0] half,      // P/2 of the latched prescale
  output logic                  last_edge  // edge_cnt == P-1
);

  logic [PRESCALE_W-1:0] p_q, p_d;
  logic [PRESCALE_W-1:0] edge_q, edge_d;
  logic [3:0]            bit_q, bit_d;

  // The last idle cycle loads P, so the frame keeps the value seen at its start.
  assign last_edge = (edge_q == p_q - PRESCALE_W'(1));
  assign half      = p_q >> 1;
  assign edge_cnt  = edge_q;
  assign bit_cnt   = bit_q;

  // Next counter values: clear, wrap at P-1 into the next bit, or count.
  always_comb begin
    p_d    = load ? prescale : p_q;
    edge_d = edge_q;
    bit_d  = bit_q;
    if (clr) begin
      edge_d = '0;
      bit_d  = '0;
    end else if (last_edge) begin
      edge_d = '0;
      bit_d  = bit_q + 4'd1;
    end else begin
      edge_d = edge_q + PRESCALE_W'(1);
    end
  end

  // Counter registers.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      p_q    <= '0;
      edge_q <= '0;
      bit_q  <= '0;
    end else begin
      p_q    <= p_d;
      edge_q <= edge_d;
      bit_q  <= bit_d;
    end
  end

endmodule

// File: rtl/uart_rx_fsm.sv
// UART RX control FSM: frame sequencing, checker/deserializer enables, frame result.
module uart_rx_fsm
  import uart_rx_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int PRESCALE_W = PRESCALE_W_DEF
) (
  input  logic          CLK,
  input  logic          RST_n,
  uart_rx_fsm_if.master bus
);

  state_e state_q, state_d;

  logic [PRESCALE_W-1:0] half;
  logic last_edge, cnt_clr, cnt_load;
  logic arm_pt, stop_pt, frame_ok, frame_done;

  logic samp_en_q, samp_en_d;
  logic strt_en_q, strt_en_d;
  logic deser_en_q, deser_en_d;
  logic par_en_q, par_en_d;
  logic stp_en_q, stp_en_d;
  logic valid_q, valid_d;
  logic ferr_q, ferr_d;

  // Counters sit at 0 throughout IDLE and on the first START cycle.
  assign cnt_clr  = (state_q == IDLE) || (state_d == IDLE);
  assign cnt_load = (state_q == IDLE);

  uart_rx_edge_bit_counter #(.PRESCALE_W(PRESCALE_W)) u_cnt (
    .CLK       (CLK),
    .RST_n     (RST_n),
    .clr       (cnt_clr),
    .load      (cnt_load),
    .prescale  (bus.Prescale),
    .edge_cnt  (bus.edge_cnt),
    .bit_cnt   (bus.bit_cnt),
    .half      (half),
    .last_edge (last_edge)
  );

  // Enables are registered, so arm them one edge early to land on H+2.
  // H+1 never coincides with P-1 for legal P, so the state cannot change here.
  assign arm_pt     = (bus.edge_cnt == half + PRESCALE_W'(EN_OFS - 1));
  assign stop_pt    = (bus.edge_cnt == half + PRESCALE_W'(STOP_OFS));
  assign frame_done = (state_q == STOP) && stop_pt;
  assign frame_ok   = !bus.stp_err && (!bus.PAR_EN || !bus.par_err);

  // Next state and next registered outputs.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (!bus.RX_IN) state_d = START;
      START:   if (last_edge) state_d = bus.strt_glitch ? IDLE : DATA;
      DATA:    if (last_edge && (bus.bit_cnt == 4'(DATA_W)))
                 state_d = bus.PAR_EN ? PARITY : STOP;
      PARITY:  if (last_edge) state_d = STOP;
      // Leave at mid stop bit to leave margin for a back-to-back start bit.
      STOP:    if (stop_pt) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    samp_en_d  = (state_d != IDLE);
    strt_en_d  = (state_q == START)  && arm_pt;
    deser_en_d = (state_q == DATA)   && arm_pt;
    par_en_d   = (state_q == PARITY) && arm_pt;
    stp_en_d   = (state_q == STOP)   && arm_pt;
    valid_d    = frame_done && frame_ok;
    ferr_d     = frame_done && !frame_ok;
  end

  // State register and registered Moore outputs.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q    <= IDLE;
      samp_en_q  <= 1'b0;
      strt_en_q  <= 1'b0;
      deser_en_q <= 1'b0;
      par_en_q   <= 1'b0;
      stp_en_q   <= 1'b0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      samp_en_q  <= samp_en_d;
      strt_en_q  <= strt_en_d;
      deser_en_q <= deser_en_d;
      par_en_q   <= par_en_d;
      stp_en_q   <= stp_en_d;
      valid_q    <= valid_d;
      ferr_q     <= ferr_d;
    end
  end

  assign bus.dat_samp_en = samp_en_q;
  assign bus.strt_chk_en = strt_en_q;
  assign bus.deser_en    = deser_en_q;
  assign bus.par_chk_en  = par_en_q;
  assign bus.stp_chk_en  = stp_en_q;
  assign bus.data_valid  = valid_q;
  assign bus.frame_err   = ferr_q;

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Bench for uart_rx_fsm: frame-level timing model plus directed literal checks.
module tb_uart_rx_fsm;
  localparam int DW = 8;
  localparam int PW = 6;

  logic CLK = 1'b0;
  logic RST_n = 1'b0;
  always #5 CLK = ~CLK;

  uart_rx_fsm_if #(.PRESCALE_W(PW)) bus ();

  uart_rx_fsm #(.DATA_W(DW), .PRESCALE_W(PW)) dut (
    .CLK   (CLK),
    .RST_n (RST_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Outcome each emulated checker reports for the current frame.
  bit sel_gl = 1'b0, sel_par = 1'b0, sel_stp = 1'b0;

  // Emulated checkers: flag registered on the cycle after their enable, then held.
  always @(posedge CLK) begin
    if (!RST_n) begin
      bus.strt_glitch <= 1'b0;
      bus.par_err     <= 1'b0;
      bus.stp_err     <= 1'b0;
    end else begin
      if (bus.strt_chk_en) bus.strt_glitch <= sel_gl;
      if (bus.par_chk_en)  bus.par_err     <= sel_par;
      if (bus.stp_chk_en)  bus.stp_err     <= sel_stp;
    end
  end

  // Frame model: a frame starts on the edge that sees RX low while idle; cycle r
  // after that edge is bit r/P, edge r%P. Pulses at edge H+2; result after STOP H+3.
  int cyc = 0;
  bit m_act = 1'b0, m_gl, m_ok, m_par;
  int m_n0 = 0, m_P = 8, m_H = 4, m_end = 0;
  int cnt_deser = 0, cnt_valid = 0, cnt_ferr = 0, cnt_par = 0, cnt_strt = 0;
  int deser_hist [64];
  int v_bit = -1, v_edge = -1, p_bit = -1, p_edge = -1, f_edge = -1;
  int prev_bit = 0, prev_edge = 0;
  bit prev_samp = 1'b0;

  function automatic logic [16:0] dut_vec();
    return {bus.edge_cnt, bus.bit_cnt, bus.dat_samp_en, bus.strt_chk_en, bus.deser_en,
            bus.par_chk_en, bus.stp_chk_en, bus.data_valid, bus.frame_err};
  endfunction

  always @(posedge CLK) begin
    logic [16:0] exp_v, got_v;
    int rel, k, e;
    cyc++;
    if (!RST_n) m_act = 1'b0;
    else begin
      rel = cyc - m_n0;
      if ((!m_act || rel >= m_end + 2) && !bus.RX_IN) begin
        m_act = 1'b1;
        m_n0  = cyc;
        m_P   = int'(bus.Prescale);
        m_H   = m_P / 2;
        m_gl  = sel_gl;
        m_par = bus.PAR_EN;
        m_ok  = !sel_stp && (!bus.PAR_EN || !sel_par);
        m_end = m_gl ? m_P - 1 : (DW + 1 + int'(bus.PAR_EN)) * m_P + m_H + 3;
      end
    end
    rel   = cyc - m_n0;
    exp_v = '0;
    if (m_act && rel <= m_end) begin
      k = rel / m_P;
      e = rel % m_P;
      exp_v[16:11] = 6'(e);
      exp_v[10:7]  = 4'(k);
      exp_v[6]     = 1'b1;
      if (e == m_H + 2) begin
        if (k == 0)                     exp_v[5] = 1'b1;
        else if (k <= DW)               exp_v[4] = 1'b1;
        else if (m_par && k == DW + 1)  exp_v[3] = 1'b1;
        else                            exp_v[2] = 1'b1;
      end
    end else if (m_act && rel == m_end + 1 && !m_gl) begin
      exp_v[1] = m_ok;
      exp_v[0] = !m_ok;
    end
    #1;
    got_v = dut_vec();
    n_cmp++;
    if (got_v !== exp_v) begin
      n_bad++;
      if (n_bad <= 20)
        $display("FAIL cycle_%0d outputs got=%h exp=%h (edge,bit,samp,strt,deser,par,stp,valid,ferr)",
                 cyc, got_v, exp_v);
    end
    // Monitors for the directed literal checks.
    if (bus.deser_en)    begin cnt_deser++; deser_hist[bus.edge_cnt]++; end
    if (bus.strt_chk_en) cnt_strt++;
    if (bus.par_chk_en)  begin cnt_par++; p_bit = int'(bus.bit_cnt); p_edge = int'(bus.edge_cnt); end
    if (bus.data_valid)  begin cnt_valid++; v_bit = prev_bit; v_edge = prev_edge; end
    if (bus.frame_err)   cnt_ferr++;
    if (prev_samp && !bus.dat_samp_en) f_edge = prev_edge;
    prev_bit  = int'(bus.bit_cnt);
    prev_edge = int'(bus.edge_cnt);
    prev_samp = bus.dat_samp_en;
  end

  task automatic chk(input string nm, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // Drives one frame on RX_IN; starts and ends just after a negedge.
  task automatic send_frame(input int p, input bit pe, input logic [7:0] d, input bit gl,
                            input bit ps, input bit ss, input int p_new);
    logic [10:0] bits;
    int nb;
    bus.Prescale = PW'(p);
    bus.PAR_EN   = pe;
    sel_gl = gl; sel_par = ps; sel_stp = ss;
    if (gl) begin
      bus.RX_IN = 1'b0;
      idle(3);
      bus.RX_IN = 1'b1;
      idle(p + 4);
    end else begin
      if (pe) begin bits = {1'b1, ^d, d, 1'b0}; nb = 11; end
      else    begin bits = {1'b0, 1'b1, d, 1'b0}; nb = 10; end
      for (int i = 0; i < nb; i++) begin
        bus.RX_IN = bits[i];
        if (i == 4 && p_new != 0) bus.Prescale = PW'(p_new);
        idle(p);
      end
      bus.RX_IN = 1'b1;
    end
  endtask

  initial begin
    int b_deser, b_valid, b_ferr, b_par, b_strt, b_h6;
    bit hit;
    for (int i = 0; i < 64; i++) deser_hist[i] = 0;
    bus.RX_IN = 1'b1; bus.Prescale = PW'(8); bus.PAR_EN = 1'b0;
    idle(3);
    chk("reset_outputs", int'(dut_vec()), 0);
    RST_n = 1'b1;
    idle(4);
    chk("idle_outputs", int'(dut_vec()), 0);

    // 1: P=8, no parity, 0xA5
    b_deser = cnt_deser; b_valid = cnt_valid; b_h6 = deser_hist[6];
    send_frame(8, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 0);
    idle(16);
    chk("t1_deser_count", cnt_deser - b_deser, 8);
    chk("t1_deser_at_edge6", deser_hist[6] - b_h6, 8);
    chk("t1_valid_count", cnt_valid - b_valid, 1);
    chk("t1_valid_bit", v_bit, 9);
    chk("t1_valid_edge", v_edge, 7);

    // 2: P=16, parity, 0x3C, clean
    b_par = cnt_par; b_valid = cnt_valid;
    send_frame(16, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 0);
    idle(32);
    chk("t2_par_count", cnt_par - b_par, 1);
    chk("t2_par_bit", p_bit, 9);
    chk("t2_par_edge", p_edge, 10);
    chk("t2_valid_count", cnt_valid - b_valid, 1);

    // 3: start glitch, P=16
    b_deser = cnt_deser; b_valid = cnt_valid; b_ferr = cnt_ferr; b_strt = cnt_strt;
    send_frame(16, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 0);
    idle(8);
    chk("t3_strt_count", cnt_strt - b_strt, 1);
    chk("t3_deser_count", cnt_deser - b_deser, 0);
    chk("t3_no_result", (cnt_valid - b_valid) + (cnt_ferr - b_ferr), 0);
    chk("t3_exit_edge", f_edge, 15);

    // 4: stop error
    b_valid = cnt_valid; b_ferr = cnt_ferr;
    send_frame(8, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b1, 0);
    idle(16);
    chk("t4_ferr_count", cnt_ferr - b_ferr, 1);
    chk("t4_valid_count", cnt_valid - b_valid, 0);

    // 5: back-to-back at P=32, then Prescale 16->8 mid-frame
    b_valid = cnt_valid;
    send_frame(32, 1'b0, 8'h81, 1'b0, 1'b0, 1'b0, 0);
    send_frame(32, 1'b0, 8'h7E, 1'b0, 1'b0, 1'b0, 0);
    idle(64);
    chk("t5_b2b_valid_count", cnt_valid - b_valid, 2);
    b_valid = cnt_valid;
    send_frame(16, 1'b0, 8'hC3, 1'b0, 1'b0, 1'b0, 8);
    idle(32);
    chk("t5_pchg_valid_count", cnt_valid - b_valid, 1);
    chk("t5_pchg_valid_edge", v_edge, 11);

    // 6: reset in DATA bit 4
    bus.Prescale = PW'(8); bus.PAR_EN = 1'b0; sel_gl = 0; sel_par = 0; sel_stp = 0;
    b_valid = cnt_valid; b_ferr = cnt_ferr;
    bus.RX_IN = 1'b0;
    idle(8);
    bus.RX_IN = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge CLK);
      if (bus.bit_cnt == 4'd4 && bus.dat_samp_en) hit = 1'b1;
    end
    chk("t6_reached_bit4", int'(hit), 1);
    #2 RST_n = 1'b0;
    #1 chk("t6_async_clear", int'(dut_vec()), 0);
    idle(3);
    RST_n = 1'b1;
    idle(20);
    chk("t6_idle_after", int'(dut_vec()), 0);
    chk("t6_no_result", (cnt_valid - b_valid) + (cnt_ferr - b_ferr), 0);
    b_valid = cnt_valid;
    send_frame(8, 1'b0, 8'h96, 1'b0, 1'b0, 1'b0, 0);
    idle(16);
    chk("t6_frame_after_reset", cnt_valid - b_valid, 1);

    // Randomized frames, checked cycle by cycle by the model.
    for (int n = 0; n < 40; n++) begin
      int p, pn;
      p  = 8 << $urandom_range(0, 2);
      pn = ($urandom_range(0, 3) == 0) ? (8 << $urandom_range(0, 2)) : 0;
      send_frame(p, 1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 7) == 0),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), pn);
      idle($urandom_range(0, 2));
    end
    idle(80);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
